// File: rtl/uart_block_tx_sched.sv
// uart_block_tx_sched: round-robin arbiter for two 128-bit block requesters that
// serialises each granted block into 16 bytes for a UART byte transmitter.
module uart_block_tx_sched #(
  parameter int BYTE_GAP = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  input  logic [127:0] req0_data,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [127:0] req1_data,
  output logic         req1_ready,
  output logic         byte_valid,
  output logic [7:0]   byte_data,
  input  logic         byte_ready,
  output logic         busy,
  output logic         grant_id,
  output logic         done
);
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  localparam logic [15:0] GAP_LAST = 16'(BYTE_GAP - 1);
  state_t        state_q, state_d;
  logic [127:0]  buf_q, buf_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [15:0]   gap_q, gap_d;
  logic          grant_q, grant_d, last_q, last_d;
  logic          sel, accept, take;
  always_comb begin
    sel        = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    accept     = rst_n && state_q == IDLE && (req0_valid || req1_valid);
    take       = state_q == SEND && byte_ready;
    req0_ready = accept && !sel;
    req1_ready = accept && sel;
    byte_valid = state_q == SEND;
    byte_data  = buf_q[127:120];
    busy       = state_q != IDLE;
    grant_id   = grant_q;
    done       = take && cnt_q == 4'hf;
    state_d    = state_q;
    buf_d      = buf_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    grant_d    = grant_q;
    last_d     = last_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = SEND;
        buf_d   = sel ? req1_data : req0_data;
        cnt_d   = 4'd0;
        grant_d = sel;
      end
      SEND: if (take) begin
        buf_d = {buf_q[119:0], 8'h00};
        cnt_d = cnt_q + 4'd1;
        gap_d = 16'd0;
        if (done) begin
          state_d = IDLE;
          last_d  = grant_q;
        end else if (BYTE_GAP != 0) state_d = GAP;
      end
      GAP: begin
        // GAP lasts exactly BYTE_GAP cycles, so the next byte lands BYTE_GAP+1 after acceptance
        gap_d = gap_q + 16'd1;
        if (gap_q == GAP_LAST) state_d = SEND;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end
endmodule

// File: tb/tb_uart_block_tx_sched.sv
// tb_uart_block_tx_sched: directed scenario bench; a second instance with
// BYTE_GAP = 3 covers inter-byte gap timing.
module tb_uart_block_tx_sched;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req0_valid = 0, req1_valid = 0, byte_ready = 0;
  logic [127:0] req0_data = '0, req1_data = '0;
  logic req0_ready, req1_ready, byte_valid, busy, grant_id, done;
  logic [7:0] byte_data;
  logic g_req0_valid = 0, g_byte_ready = 0;
  logic [127:0] g_req0_data = '0;
  logic g_req0_ready, g_req1_ready, g_byte_valid, g_busy, g_grant_id, g_done;
  logic [7:0] g_byte_data;
  int tests = 0, fails = 0;
  localparam logic [127:0] DA = 128'h112233445566778899AABBCCDDEEFF00;
  localparam logic [127:0] DB = 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF;
  localparam logic [127:0] DX = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;

  always #5 clk = ~clk;

  uart_block_tx_sched #(.BYTE_GAP(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .busy(busy), .grant_id(grant_id), .done(done));

  uart_block_tx_sched #(.BYTE_GAP(3)) dut_g (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(g_req0_valid), .req0_data(g_req0_data), .req0_ready(g_req0_ready),
    .req1_valid(1'b0), .req1_data(128'h0), .req1_ready(g_req1_ready),
    .byte_valid(g_byte_valid), .byte_data(g_byte_data), .byte_ready(g_byte_ready),
    .busy(g_busy), .grant_id(g_grant_id), .done(g_done));

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Receives one block from the gap-0 instance, starting on its first SEND cycle.
  task automatic rx_block(input logic [127:0] d, input logic gid, input int stall_at,
                          input int stall_n, input bit flip);
    int idx = 0, st = 0;
    for (int c = 0; c < 40 && idx < 16; c++) begin
      byte_ready = !(idx == stall_at && st < stall_n);
      if (flip && idx == 8 && byte_ready) req1_data = ~req1_data;
      #1;
      tests++;
      if (byte_valid !== 1'b1 || byte_data !== d[127-8*idx -: 8] || grant_id !== gid) begin
        fails++;
        $display("FAIL rx_byte idx=%0d: valid=%b data=%h gid=%b, want 1 %h %b",
                 idx, byte_valid, byte_data, grant_id, d[127-8*idx -: 8], gid);
      end
      tests++;
      if (done !== (byte_ready && idx == 15) || req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1) begin
        fails++;
        $display("FAIL rx_ctrl idx=%0d: done=%b r0=%b r1=%b busy=%b, want done=%b r0=0 r1=0 busy=1",
                 idx, done, req0_ready, req1_ready, busy, byte_ready && idx == 15);
      end
      if (!byte_ready) st++;
      else idx++;
      tick;
    end
    tests++;
    if (idx != 16) begin
      fails++;
      $display("FAIL rx_count: got %0d bytes, want 16", idx);
    end
  endtask

  task automatic test_reset;
    req0_valid = 1;
    req1_valid = 1;
    #1;
    tests++;
    if (req0_ready !== 0 || req1_ready !== 0 || byte_valid !== 0 || byte_data !== 8'h00 ||
        busy !== 0 || done !== 0 || grant_id !== 0) begin
      fails++;
      $display("FAIL reset: r0=%b r1=%b bv=%b bd=%h busy=%b done=%b gid=%b, want all 0",
               req0_ready, req1_ready, byte_valid, byte_data, busy, done, grant_id);
    end
    req0_valid = 0;
    req1_valid = 0;
    tick;
    rst_n = 1;
    #1;
    tests++;
    if (busy !== 0 || byte_valid !== 0 || req0_ready !== 0) begin
      fails++;
      $display("FAIL reset_release: busy=%b bv=%b r0=%b, want 0 0 0", busy, byte_valid, req0_ready);
    end
  endtask

  task automatic test_tie;
    tick;
    req0_valid = 1; req0_data = DA;
    req1_valid = 1; req1_data = DB;
    for (int k = 0; k < 4; k++) begin
      #1;
      tests++;
      if (req0_ready !== (k % 2 == 0) || req1_ready !== (k % 2 == 1)) begin
        fails++;
        $display("FAIL tie_grant k=%0d: r0=%b r1=%b, want %b %b", k, req0_ready, req1_ready, k % 2 == 0, k % 2 == 1);
      end
      tick;
      rx_block((k % 2) ? DB : DA, 1'(k % 2), -1, 0, 0);
    end
    req0_valid = 0;
    req1_valid = 0;
  endtask

  task automatic test_single;
    req0_valid = 1; req0_data = DA; byte_ready = 1;
    #1;
    tests++;
    if (req0_ready !== 1 || req1_ready !== 0) begin
      fails++;
      $display("FAIL single_ready: r0=%b r1=%b, want 1 0", req0_ready, req1_ready);
    end
    tick;
    req0_valid = 0;
    rx_block(DA, 0, -1, 0, 0);
    #1;
    tests++;
    if (busy !== 0 || byte_valid !== 0 || done !== 0) begin
      fails++;
      $display("FAIL single_end: busy=%b bv=%b done=%b, want 0 0 0", busy, byte_valid, done);
    end
  endtask

  task automatic test_backpressure;
    tick;
    req0_valid = 1; req0_data = DA;
    tick;
    req0_valid = 0;
    rx_block(DA, 0, 2, 5, 0);
  endtask

  task automatic test_midblock;
    req0_valid = 1; req0_data = DA;
    tick;
    req0_valid = 0;
    req1_valid = 1; req1_data = DX;
    rx_block(DA, 0, -1, 0, 1);
    #1;
    tests++;
    if (req1_ready !== 1 || req0_ready !== 0) begin
      fails++;
      $display("FAIL mid_accept: r1=%b r0=%b, want 1 0", req1_ready, req0_ready);
    end
    tick;
    req1_valid = 0;
    rx_block(~DX, 1, -1, 0, 0);
  endtask

  task automatic test_reset_mid;
    req1_valid = 1; req1_data = DB; byte_ready = 1;
    tick;
    req1_valid = 0;
    for (int i = 0; i < 7; i++) begin
      #1;
      tests++;
      if (byte_data !== DB[127-8*i -: 8]) begin
        fails++;
        $display("FAIL rmid_byte i=%0d: %h, want %h", i, byte_data, DB[127-8*i -: 8]);
      end
      tick;
    end
    req1_valid = 1; req1_data = DX;
    rst_n = 0;
    #1;
    tests++;
    if (byte_valid !== 0 || byte_data !== 8'h00 || busy !== 0 || done !== 0 || grant_id !== 0 ||
        req0_ready !== 0 || req1_ready !== 0) begin
      fails++;
      $display("FAIL rmid_reset: bv=%b bd=%h busy=%b done=%b gid=%b r0=%b r1=%b, want all 0",
               byte_valid, byte_data, busy, done, grant_id, req0_ready, req1_ready);
    end
    tick;
    rst_n = 1;
    #1;
    tests++;
    if (req1_ready !== 1) begin
      fails++;
      $display("FAIL rmid_ready: r1=%b, want 1", req1_ready);
    end
    tick;
    req1_valid = 0;
    rx_block(DX, 1, -1, 0, 0);
  endtask

  task automatic test_gap;
    g_req0_valid = 1; g_req0_data = DA; g_byte_ready = 1;
    #1;
    tests++;
    if (g_req0_ready !== 1) begin
      fails++;
      $display("FAIL gap_ready: r0=%b, want 1", g_req0_ready);
    end
    tick;
    g_req0_valid = 0;
    for (int idx = 0; idx < 16; idx++) begin
      #1;
      tests++;
      if (g_byte_valid !== 1 || g_byte_data !== DA[127-8*idx -: 8] || g_done !== (idx == 15)) begin
        fails++;
        $display("FAIL gap_byte idx=%0d: bv=%b bd=%h done=%b, want 1 %h %b",
                 idx, g_byte_valid, g_byte_data, g_done, DA[127-8*idx -: 8], idx == 15);
      end
      tick;
      if (idx < 15) begin
        for (int g = 0; g < 3; g++) begin
          #1;
          tests++;
          if (g_byte_valid !== 0 || g_busy !== 1 || g_done !== 0) begin
            fails++;
            $display("FAIL gap_idle idx=%0d g=%0d: bv=%b busy=%b done=%b, want 0 1 0",
                     idx, g, g_byte_valid, g_busy, g_done);
          end
          tick;
        end
      end
    end
    #1;
    tests++;
    if (g_busy !== 0 || g_byte_valid !== 0) begin
      fails++;
      $display("FAIL gap_end: busy=%b bv=%b, want 0 0", g_busy, g_byte_valid);
    end
  endtask

  initial begin
    tick;
    tick;
    test_reset;
    test_tie;
    test_single;
    test_backpressure;
    test_midblock;
    test_reset_mid;
    test_gap;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
